// File: rtl/hub75_fb_arbiter.sv
// Frame-buffer ownership arbiter between the HUB75 read-out (RD) and row write-in (WI) engines.
// Optional macro HUB75_FB_ARB_RR_EN: round-robin tie-break on simultaneous requests (default: fixed RD priority).
module hub75_fb_arbiter #(
  parameter int unsigned FB_AW = 13,
  parameter int unsigned FB_DW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req,
  output logic             rd_gnt,
  input  logic             rd_rel,
  input  logic [FB_AW-1:0] rd_addr,
  input  logic             rd_rden,
  output logic [FB_DW-1:0] rd_data,
  input  logic             wi_req,
  output logic             wi_gnt,
  input  logic             wi_rel,
  input  logic [FB_AW-1:0] wi_addr,
  input  logic [FB_DW-1:0] wi_data,
  input  logic             wi_wren,
  output logic [FB_AW-1:0] fb_addr,
  output logic [FB_DW-1:0] fb_data,
  output logic             fb_wren,
  output logic             fb_rden,
  input  logic [FB_DW-1:0] fb_rdata,
  output logic             busy,
  output logic             proto_err
);

  typedef enum logic [1:0] {IDLE, OWN_RD, OWN_WI} state_t;

  state_t state, state_nxt;
  logic   rd_gnt_nxt, wi_gnt_nxt, proto_err_nxt;
  logic   pick_rd, viol;

`ifdef HUB75_FB_ARB_RR_EN
  logic last_wi, last_wi_nxt;
  // Tie goes to whoever did not own last; a lone requester always wins.
  assign pick_rd = rd_req && (!wi_req || last_wi);
`else
  assign pick_rd = rd_req;
`endif

  // Any strobe or release from a non-owner, or request+release together while idle.
  assign viol = (rd_rel  && (state != OWN_RD)) ||
                (wi_rel  && (state != OWN_WI)) ||
                (rd_rden && (state != OWN_RD)) ||
                (wi_wren && (state != OWN_WI)) ||
                ((state == IDLE) && rd_req && rd_rel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_gnt    <= 1'b0;
      wi_gnt    <= 1'b0;
      proto_err <= 1'b0;
`ifdef HUB75_FB_ARB_RR_EN
      last_wi   <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      rd_gnt    <= rd_gnt_nxt;
      wi_gnt    <= wi_gnt_nxt;
      proto_err <= proto_err_nxt;
`ifdef HUB75_FB_ARB_RR_EN
      last_wi   <= last_wi_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    rd_gnt_nxt    = 1'b0;
    wi_gnt_nxt    = 1'b0;
    proto_err_nxt = proto_err | viol;
`ifdef HUB75_FB_ARB_RR_EN
    last_wi_nxt   = last_wi;
`endif
    case (state)
      IDLE: begin
        if (pick_rd) begin
          state_nxt  = OWN_RD;
          rd_gnt_nxt = 1'b1;
`ifdef HUB75_FB_ARB_RR_EN
          last_wi_nxt = 1'b0;
`endif
        end else if (wi_req) begin
          state_nxt  = OWN_WI;
          wi_gnt_nxt = 1'b1;
`ifdef HUB75_FB_ARB_RR_EN
          last_wi_nxt = 1'b1;
`endif
        end
      end
      OWN_RD:  if (rd_rel) state_nxt = IDLE;
      OWN_WI:  if (wi_rel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Port mux follows registered ownership; non-owner strobes are dropped.
  always_comb begin
    fb_addr = '0;
    fb_data = '0;
    fb_wren = 1'b0;
    fb_rden = 1'b0;
    case (state)
      OWN_RD: begin
        fb_addr = rd_addr;
        fb_rden = rd_rden;
      end
      OWN_WI: begin
        fb_addr = wi_addr;
        fb_data = wi_data;
        fb_wren = wi_wren;
      end
      default: ;
    endcase
  end

  assign rd_data = fb_rdata;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// Self-checking bench for hub75_fb_arbiter: grant order via scoreboard queue, datapath and error flag via direct checks.
module tb_hub75_fb_arbiter;

  localparam int unsigned FB_AW = 13;
  localparam int unsigned FB_DW = 16;
  localparam int WHO_RD = 0;
  localparam int WHO_WI = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             rd_req, rd_rel, rd_rden, rd_gnt;
  logic [FB_AW-1:0] rd_addr;
  logic [FB_DW-1:0] rd_data;
  logic             wi_req, wi_rel, wi_wren, wi_gnt;
  logic [FB_AW-1:0] wi_addr;
  logic [FB_DW-1:0] wi_data;
  logic [FB_AW-1:0] fb_addr;
  logic [FB_DW-1:0] fb_data;
  logic             fb_wren, fb_rden;
  logic [FB_DW-1:0] fb_rdata;
  logic             busy, proto_err;

  int checks = 0;
  int errors = 0;
  int gnt_q[$];
  int first_who, second_who;

  hub75_fb_arbiter #(.FB_AW(FB_AW), .FB_DW(FB_DW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_rel(rd_rel), .rd_addr(rd_addr),
    .rd_rden(rd_rden), .rd_data(rd_data),
    .wi_req(wi_req), .wi_gnt(wi_gnt), .wi_rel(wi_rel), .wi_addr(wi_addr),
    .wi_data(wi_data), .wi_wren(wi_wren),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_wren(fb_wren), .fb_rden(fb_rden),
    .fb_rdata(fb_rdata), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every grant pulse pops the scoreboard and must name the expected requester.
  always begin
    @(posedge clk);
    #1;
    if (rd_gnt || wi_gnt) begin
      if (gnt_q.size() == 0) begin
        chk("gnt_unexpected", {30'd0, rd_gnt, wi_gnt}, 32'd0);
      end else begin
        int who;
        who = gnt_q.pop_front();
        chk("gnt_who", {30'd0, rd_gnt, wi_gnt}, (who == WHO_RD) ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin
    rst = 1'b1;
    rd_req = 0; rd_rel = 0; rd_rden = 0; rd_addr = '0;
    wi_req = 0; wi_rel = 0; wi_wren = 0; wi_addr = '0; wi_data = '0;
    fb_rdata = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_perr", 32'(proto_err), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_gnt", {30'd0, rd_gnt, wi_gnt}, 32'd0);

    // WI ownership and write
    wi_req = 1; gnt_q.push_back(WHO_WI);
    step();
    chk("wi_gnt_pulse", 32'(wi_gnt), 32'd1);
    chk("wi_busy", 32'(busy), 32'd1);
    wi_req = 0; wi_wren = 1; wi_addr = 13'h0123; wi_data = 16'hBEEF;
    #1;
    chk("wi_fb_wren", 32'(fb_wren), 32'd1);
    chk("wi_fb_addr", 32'(fb_addr), 32'h0123);
    chk("wi_fb_data", 32'(fb_data), 32'hBEEF);
    chk("wi_fb_rden", 32'(fb_rden), 32'd0);
    step();
    chk("wi_gnt_single", 32'(wi_gnt), 32'd0);
    wi_wren = 0; wi_rel = 1;
    step();
    wi_rel = 0;
    chk("wi_rel_idle", 32'(busy), 32'd0);
    chk("wi_fb_idle", 32'(fb_wren), 32'd0);

    // RD ownership and read passthrough
    rd_req = 1; gnt_q.push_back(WHO_RD);
    step();
    chk("rd_gnt_pulse", 32'(rd_gnt), 32'd1);
    rd_req = 0; rd_rden = 1; rd_addr = 13'h1FFF; fb_rdata = 16'h5A5A;
    #1;
    chk("rd_fb_rden", 32'(fb_rden), 32'd1);
    chk("rd_fb_addr", 32'(fb_addr), 32'h1FFF);
    chk("rd_data", 32'(rd_data), 32'h5A5A);
    chk("rd_fb_wren", 32'(fb_wren), 32'd0);
    chk("rd_fb_data", 32'(fb_data), 32'd0);
    step();
    rd_rden = 0; rd_rel = 1;
    step();
    rd_rel = 0;
    chk("no_perr_yet", 32'(proto_err), 32'd0);

    // Simultaneous requests after an RD ownership
`ifdef HUB75_FB_ARB_RR_EN
    first_who = WHO_WI; second_who = WHO_RD;
`else
    first_who = WHO_RD; second_who = WHO_WI;
`endif
    rd_req = 1; wi_req = 1;
    gnt_q.push_back(first_who); gnt_q.push_back(second_who);
    step();
    chk("tie_first_rd", 32'(rd_gnt), (first_who == WHO_RD) ? 32'd1 : 32'd0);
    if (first_who == WHO_RD) rd_req = 0; else wi_req = 0;
    step();
    if (first_who == WHO_RD) rd_rel = 1; else wi_rel = 1;
    step();
    rd_rel = 0; wi_rel = 0;
    chk("tie_turnaround_busy", 32'(busy), 32'd0);
    chk("tie_turnaround_gnt", {30'd0, rd_gnt, wi_gnt}, 32'd0);
    step();
    chk("tie_second_gnt", {30'd0, rd_gnt, wi_gnt}, (second_who == WHO_RD) ? 32'd2 : 32'd1);
    rd_req = 0; wi_req = 0;

    // Non-owner write strobe while second owner holds the port
    if (second_who == WHO_RD) begin
      wi_wren = 1;
      #1;
      chk("blocked_wren", 32'(fb_wren), 32'd0);
      step();
      wi_wren = 0;
    end else begin
      rd_rden = 1;
      #1;
      chk("blocked_rden", 32'(fb_rden), 32'd0);
      step();
      rd_rden = 0;
    end
    chk("perr_set", 32'(proto_err), 32'd1);
    if (second_who == WHO_RD) rd_rel = 1; else wi_rel = 1;
    step();
    rd_rel = 0; wi_rel = 0;
    step();
    chk("perr_sticky", 32'(proto_err), 32'd1);

    // Zero-length WI ownership; pending RD granted two cycles after rel
    wi_req = 1; gnt_q.push_back(WHO_WI);
    step();
    chk("zl_wi_gnt", 32'(wi_gnt), 32'd1);
    wi_req = 0; wi_rel = 1; rd_req = 1; gnt_q.push_back(WHO_RD);
    step();
    wi_rel = 0;
    chk("zl_idle", 32'(busy), 32'd0);
    chk("zl_rd_not_yet", 32'(rd_gnt), 32'd0);
    step();
    chk("zl_rd_gnt", 32'(rd_gnt), 32'd1);
    rd_req = 0; rd_rel = 1;
    step();
    rd_rel = 0;

    // Reset in the middle of a WI ownership with the write strobe up
    wi_req = 1; gnt_q.push_back(WHO_WI);
    step();
    wi_wren = 1;
    step();
    chk("pre_rst_wren", 32'(fb_wren), 32'd1);
    rst = 1;
    step();
    chk("rst_mid_wren", 32'(fb_wren), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_perr", 32'(proto_err), 32'd0);
    rst = 0; wi_wren = 0; gnt_q.push_back(WHO_WI);
    step();
    chk("post_rst_wi_gnt", 32'(wi_gnt), 32'd1);
    wi_req = 0; wi_rel = 1;
    step();
    wi_rel = 0;
    step();
    chk("post_rst_perr", 32'(proto_err), 32'd0);
    chk("gnt_q_drained", 32'(gnt_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub75_fb_arbiter.md
Name: hub75_fb_arbiter

Overview:
Shares the single-port HUB75 frame buffer between two requesters: the read-out engine (RD) and the row write-in engine (WI).
- Both use the req/gnt/rel ownership handshake.
- The arbiter grants exclusive ownership and muxes the owner's address, data and strobes onto the frame buffer port.
- It returns read data to RD and flags protocol violations.

Parameters:
FB_AW, 13, frame buffer address width
FB_DW, 16, frame buffer data width

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
rd_req  in  1  RD ownership request (level, held until rd_gnt)
rd_gnt  out  1  RD grant, single-cycle pulse
rd_rel  in  1  RD release, single-cycle pulse
rd_addr  in  FB_AW  RD address
rd_rden  in  1  RD read strobe
rd_data  out  FB_DW  read data to RD
wi_req  in  1  WI ownership request (level, held until wi_gnt)
wi_gnt  out  1  WI grant, single-cycle pulse
wi_rel  in  1  WI release, single-cycle pulse
wi_addr  in  FB_AW  WI address
wi_data  in  FB_DW  WI write data
wi_wren  in  1  WI write strobe
fb_addr  out  FB_AW  frame buffer address
fb_data  out  FB_DW  frame buffer write data
fb_wren  out  1  frame buffer write enable
fb_rden  out  1  frame buffer read enable
fb_rdata  in  FB_DW  frame buffer read data
busy  out  1  high while any owner is active
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- FSM states: IDLE, OWN_RD, OWN_WI. All state and gnt outputs are registered.
- Reset (rst high at an edge) forces:
  - state=IDLE, rd_gnt=wi_gnt=0, proto_err=0, last-owner=WI.
  - This applies mid-ownership too. Requests still asserted after reset are re-arbitrated normally.
- IDLE, rd_req=1 at edge → OWN_RD, and rd_gnt=1 for that one following cycle. Same for WI.
- Both requests high in IDLE: RD wins (fixed priority); WI stays pending.
- OWN_x with x_rel=1 at edge → IDLE.
  - IDLE always lasts at least one cycle between owners (one turnaround cycle).
  - Minimum rel-to-next-gnt latency is 2 cycles.
- rel sampled in the grant cycle is legal (zero-length ownership): state returns to IDLE next edge.
- Requests seen while in OWN_x are not acted on until IDLE. The non-owner's req level is held by the requester, so nothing is lost.
- Datapath mux is combinational from the registered state:
  - OWN_RD: fb_addr=rd_addr, fb_rden=rd_rden, fb_wren=0, fb_data=0.
  - OWN_WI: fb_addr=wi_addr, fb_data=wi_data, fb_wren=wi_wren, fb_rden=0.
  - IDLE: fb_addr=0, fb_data=0, fb_wren=0, fb_rden=0.
- Strobes are gated: the owner's strobes are valid from its gnt cycle onward. Non-owner strobes never reach the fb port.
- rd_data = fb_rdata, unregistered passthrough. The frame buffer read latency (1 cycle) is RD's concern.
- busy = (state != IDLE).
- proto_err is set, and stays set until rst, on any of:
  - rel from a non-owner;
  - rd_rden while not OWN_RD;
  - wi_wren while not OWN_WI;
  - rd_req and rd_rel high in the same cycle while IDLE.
  - Offending strobes are blocked; the FSM is unaffected.
- No counters wrap.
- Ownership has no timeout; the owner must release.

Optional Feature:
Macro HUB75_FB_ARB_RR_EN.
- Defined: when both rd_req and wi_req are high in IDLE, grant the requester that did not own last. The last-owner register updates on every grant.
- Undefined: fixed RD priority and the last-owner register is not built. Behaviour with a single requester is identical in both builds.

Test Plan:
- Reset then wi_req=1 → wi_gnt pulses 1 cycle; busy=1. wi_wren=1, wi_addr=0x0123, wi_data=0xBEEF → fb_wren=1, fb_addr=0x0123, fb_data=0xBEEF. wi_rel → busy=0 next cycle.
- rd_req and wi_req rise in the same cycle (RR undefined) → rd_gnt first. rd_rel → one IDLE cycle → wi_gnt. RR defined, after a prior RD ownership → wi_gnt first.
- RD owns; wi_wren=1 → fb_wren stays 0 and proto_err=1. proto_err holds until rst.
- RD owns; rd_rden=1, rd_addr=0x1FFF, fb_rdata=0x5A5A → fb_rden=1, fb_addr=0x1FFF, rd_data=0x5A5A, fb_wren=0.
- wi_rel asserted in the wi_gnt cycle → IDLE next cycle. A pending rd_req is granted 2 cycles after the rel.
- rst asserted during OWN_WI with wi_wren=1 → next cycle fb_wren=0, busy=0. wi_req still high → wi_gnt 1 cycle after rst deasserts.
